// File: rtl/scl_gen_multi_pkg.sv
// rtl/scl_gen_multi_pkg.sv - shared encodings and preset half-period helper for the SCL generator
package scl_gen_multi_pkg;

  typedef enum logic [1:0] {
    MODE_100K = 2'd0,
    MODE_400K = 2'd1,
    MODE_1M   = 2'd2,
    MODE_CUST = 2'd3
  } scl_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOW       = 2'd1,
    ST_HIGH_WAIT = 2'd2,
    ST_HIGH      = 2'd3
  } scl_state_e;

  localparam int unsigned MIN_DIV = 8;

  // Half-period in system clocks for the fixed-rate modes; custom falls back to 100k.
  function automatic int unsigned preset_half(input int unsigned clk_hz, input logic [1:0] mode);
    case (scl_mode_e'(mode))
      MODE_400K: return clk_hz / (2 * 400_000);
      MODE_1M:   return clk_hz / (2 * 1_000_000);
      default:   return clk_hz / (2 * 100_000);
    endcase
  endfunction

endpackage

// File: rtl/scl_gen_multi_sync.sv
// rtl/scl_gen_multi_sync.sv - flop chain synchroniser for the pad SCL level, resets to released (1)
module scl_gen_multi_sync #(
  parameter int STAGES = 1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_ff;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ff <= '1;
    end else begin
      r_ff <= (r_ff << 1) | STAGES'(i_d);
    end
  end

  assign o_q = r_ff[STAGES-1];

endmodule

// File: rtl/scl_gen_multi.sv
// rtl/scl_gen_multi.sv - multi-rate I2C SCL generator with phase strobes, clock stretching and stretch timeout
module scl_gen_multi
  import scl_gen_multi_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned DIV_W       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 3_500_000
) (
  input  logic             I_clk_100Mhz,
  input  logic             I_rst,
  input  logic             I_SCL_en,
  input  logic [1:0]       I_mode,
  input  logic [DIV_W-1:0] I_div_custom,
  input  logic             I_SCL_in,
  output logic             O_SCL_POS,
  output logic             O_SCL_HIG,
  output logic             O_SCL_NEG,
  output logic             O_SCL_LOW,
  output logic             O_SCL,
  output logic             O_SCL_oe,
  output logic             O_stretch,
  output logic             O_timeout
);

  localparam int TO_W = $clog2(TIMEOUT_CYC);

  scl_state_e       r_st;
  logic [DIV_W-1:0] r_cnt;
  logic [TO_W-1:0]  r_tcnt;
  logic [DIV_W-1:0] r_h;
  logic             r_scl, r_oe, r_neg, r_low, r_pos, r_hig, r_str, r_to;

  scl_state_e       w_st_n;
  logic [DIV_W-1:0] w_cnt_n, w_h_n, w_h_sel, w_half, w_cnt_inc;
  logic [TO_W-1:0]  w_tcnt_n;
  logic             w_neg_n, w_low_n, w_pos_n, w_hig_n, w_to_n;
  logic             w_last, w_scl_early;

  // The state register acts as the last synchroniser stage, so the chain here is one flop shorter.
  scl_gen_multi_sync #(.STAGES(SYNC_STAGES - 1)) u_sync (
    .i_clk (I_clk_100Mhz),
    .i_rst (I_rst),
    .i_d   (I_SCL_in),
    .o_q   (w_scl_early)
  );

  always_comb begin
    w_h_sel = DIV_W'(preset_half(CLK_FREQ_HZ, I_mode));
    if (scl_mode_e'(I_mode) == MODE_CUST) begin
      w_h_sel = (I_div_custom < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : I_div_custom;
    end
  end

  assign w_half    = r_h >> 1;
  assign w_cnt_inc = r_cnt + DIV_W'(1);
  assign w_last    = (r_cnt == r_h - DIV_W'(1));

  always_comb begin
    w_st_n   = r_st;
    w_cnt_n  = r_cnt;
    w_tcnt_n = '0;
    w_h_n    = r_h;
    w_neg_n  = 1'b0;
    w_low_n  = 1'b0;
    w_pos_n  = 1'b0;
    w_hig_n  = 1'b0;
    w_to_n   = 1'b0;
    case (r_st)
      ST_IDLE: begin
        w_cnt_n = '0;
        if (I_SCL_en) begin
          w_st_n  = ST_LOW;
          w_h_n   = w_h_sel;
          w_neg_n = 1'b1;
        end
      end
      ST_LOW: begin
        if (w_last) begin
          w_st_n  = ST_HIGH_WAIT;
          w_cnt_n = '0;
        end else begin
          w_cnt_n = w_cnt_inc;
          w_low_n = (w_cnt_inc == w_half);
        end
      end
      ST_HIGH_WAIT: begin
        if (w_scl_early) begin
          w_st_n  = ST_HIGH;
          w_cnt_n = DIV_W'(SYNC_STAGES);
          w_pos_n = 1'b1;
        end else if (r_tcnt == TO_W'(TIMEOUT_CYC - 1)) begin
          w_st_n  = ST_IDLE;
          w_cnt_n = '0;
          w_to_n  = 1'b1;
        end else begin
          w_cnt_n  = w_cnt_inc;
          w_tcnt_n = r_tcnt + TO_W'(1);
        end
      end
      default: begin
        if (w_last) begin
          w_cnt_n = '0;
          if (I_SCL_en) begin
            w_st_n  = ST_LOW;
            w_h_n   = w_h_sel;
            w_neg_n = 1'b1;
          end else begin
            w_st_n = ST_IDLE;
          end
        end else begin
          w_cnt_n = w_cnt_inc;
          w_hig_n = (w_cnt_inc == w_half);
        end
      end
    endcase
  end

  always_ff @(posedge I_clk_100Mhz) begin
    if (I_rst) begin
      r_st   <= ST_IDLE;
      r_cnt  <= '0;
      r_tcnt <= '0;
      r_h    <= '0;
      r_scl  <= 1'b1;
      r_oe   <= 1'b0;
      r_neg  <= 1'b0;
      r_low  <= 1'b0;
      r_pos  <= 1'b0;
      r_hig  <= 1'b0;
      r_str  <= 1'b0;
      r_to   <= 1'b0;
    end else begin
      r_st   <= w_st_n;
      r_cnt  <= w_cnt_n;
      r_tcnt <= w_tcnt_n;
      r_h    <= w_h_n;
      r_scl  <= (w_st_n != ST_LOW);
      r_oe   <= (w_st_n == ST_LOW);
      r_neg  <= w_neg_n;
      r_low  <= w_low_n;
      r_pos  <= w_pos_n;
      r_hig  <= w_hig_n;
      r_str  <= (w_st_n == ST_HIGH_WAIT) && (w_tcnt_n >= TO_W'(SYNC_STAGES));
      r_to   <= w_to_n;
    end
  end

  assign O_SCL     = r_scl;
  assign O_SCL_oe  = r_oe;
  assign O_SCL_NEG = r_neg;
  assign O_SCL_LOW = r_low;
  assign O_SCL_POS = r_pos;
  assign O_SCL_HIG = r_hig;
  assign O_stretch = r_str;
  assign O_timeout = r_to;

endmodule
